// File: rtl/riscv_multicycle_control.sv
// Multi-cycle RV32 control FSM: fetch/decode/execute/memory/writeback with
// per-state datapath enables, bounded memory-ready waits, traps and a retire counter.
module riscv_multicycle_control #(
  parameter bit          ENABLE_BRANCH_FULL = 1'b1,
  parameter int unsigned MEM_WAIT_LIMIT     = 8,
  parameter int unsigned COUNTER_WIDTH      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              instruction,
  input  logic                     memReady,
  input  logic                     isEqual,
  input  logic                     isLessThan,
  input  logic                     isLessThanUnsigned,
  output logic                     pcWriteEnable,
  output logic                     irWriteEnable,
  output logic                     memAddrSelect,
  output logic [2:0]               pcSelect,
  output logic [1:0]               op1Select,
  output logic [2:0]               op2Select,
  output logic [3:0]               aluFunction,
  output logic [1:0]               writebackSelect,
  output logic                     regFileWriteEnable,
  output logic                     memoryReadEnable,
  output logic                     memoryWriteEnable,
  output logic                     exception,
  output logic [1:0]               exceptionCause,
  output logic [2:0]               state,
  output logic [COUNTER_WIDTH-1:0] retiredCount
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] PC_4 = 3'd0, PC_BRANCH = 3'd1, PC_JUMP = 3'd2, PC_JALR = 3'd3, PC_EXC = 3'd4;
  localparam logic [1:0] OP1_RS1 = 2'd0, OP1_ZERO = 2'd1, OP1_PC = 2'd2;
  localparam logic [2:0] OP2_RS2 = 3'd0, OP2_IMM_I = 3'd1, OP2_IMM_S = 3'd2, OP2_IMM_U = 3'd3, OP2_IMM_J = 3'd4;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1, CAUSE_TIMEOUT = 2'd2;

  state_t                   state_q, state_d;
  logic [7:0]               wait_q, wait_d;
  logic [1:0]               cause_q, cause_d;
  logic [COUNTER_WIDTH-1:0] retired_q;
  logic                     retire;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal, is_load, is_store, is_branch, is_jal, is_jalr, taken, timed_out;
  logic [1:0] dec_op1;
  logic [2:0] dec_op2;
  logic [3:0] dec_alu;
  logic       unused_instr_bits;

  logic       pc_we, ir_we, mas, rf_we, mre, mwe, exc;
  logic [2:0] pcs;
  logic [1:0] op1, wbs;
  logic [2:0] op2;
  logic [3:0] alu;

  assign opcode            = instruction[6:0];
  assign funct3            = instruction[14:12];
  assign funct7            = instruction[31:25];
  assign unused_instr_bits = ^{instruction[24:15], instruction[11:7]};
  assign timed_out         = (wait_q == 8'(MEM_WAIT_LIMIT - 1));

  // Instruction decode: legality, class and ALU operand/function selects
  always_comb begin
    legal = 1'b1; is_load = 1'b0; is_store = 1'b0; is_branch = 1'b0;
    is_jal = 1'b0; is_jalr = 1'b0;
    dec_op1 = OP1_RS1; dec_op2 = OP2_RS2; dec_alu = ALU_ADD;
    case (opcode)
      OPC_LUI:   begin dec_op1 = OP1_ZERO; dec_op2 = OP2_IMM_U; end
      OPC_AUIPC: begin dec_op1 = OP1_PC;   dec_op2 = OP2_IMM_U; end
      OPC_JAL:   begin is_jal = 1'b1; dec_op1 = OP1_PC; dec_op2 = OP2_IMM_J; end
      OPC_JALR:  begin is_jalr = 1'b1; dec_op2 = OP2_IMM_I; end
      OPC_OPIMM: begin
        dec_op2 = OP2_IMM_I;
        dec_alu = {(funct3 == 3'b101) & funct7[5], funct3};
      end
      OPC_OP: begin
        legal   = (funct7 == 7'h00) || (funct7 == 7'h20);
        dec_alu = {funct7[5], funct3};
      end
      OPC_LOAD:  begin is_load = 1'b1;  dec_op2 = OP2_IMM_I; end
      OPC_STORE: begin is_store = 1'b1; dec_op2 = OP2_IMM_S; end
      OPC_BRANCH: begin
        is_branch = 1'b1;
        legal     = (funct3[2:1] != 2'b01) && (ENABLE_BRANCH_FULL || !funct3[2]);
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = isEqual;
      3'b001:  taken = !isEqual;
      3'b100:  taken = isLessThan;
      3'b101:  taken = !isLessThan;
      3'b110:  taken = isLessThanUnsigned;
      3'b111:  taken = !isLessThanUnsigned;
      default: taken = 1'b0;
    endcase
  end

  // Next-state and per-state datapath controls
  always_comb begin
    state_d = S_FETCH; wait_d = 8'd0; cause_d = cause_q; retire = 1'b0;
    pc_we = 1'b0; ir_we = 1'b0; mas = 1'b0; pcs = PC_4;
    op1 = OP1_RS1; op2 = OP2_RS2; alu = ALU_ADD; wbs = WB_ALU;
    rf_we = 1'b0; mre = 1'b0; mwe = 1'b0; exc = 1'b0;
    case (state_q)
      S_FETCH: begin
        mre = 1'b1;
        if (memReady) begin
          ir_we = 1'b1; state_d = S_DECODE;
        end else if (timed_out) begin
          cause_d = CAUSE_TIMEOUT; state_d = S_TRAP;
        end else begin
          state_d = S_FETCH; wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (legal) state_d = S_EXECUTE;
        else begin cause_d = CAUSE_ILLEGAL; state_d = S_TRAP; end
      end
      S_EXECUTE: begin
        op1 = dec_op1; op2 = dec_op2; alu = dec_alu;
        if (is_branch) begin
          pc_we = 1'b1; pcs = taken ? PC_BRANCH : PC_4; retire = 1'b1;
        end else if (is_load || is_store) state_d = S_MEMORY;
        else state_d = S_WRITEBACK;
      end
      S_MEMORY: begin
        op1 = dec_op1; op2 = dec_op2; alu = dec_alu;
        mas = 1'b1; mre = is_load; mwe = is_store;
        if (memReady) begin
          if (is_load) state_d = S_WRITEBACK;
          else begin pc_we = 1'b1; retire = 1'b1; end
        end else if (timed_out) begin
          cause_d = CAUSE_TIMEOUT; state_d = S_TRAP;
        end else begin
          state_d = S_MEMORY; wait_d = wait_q + 8'd1;
        end
      end
      S_WRITEBACK: begin
        op1 = dec_op1; op2 = dec_op2; alu = dec_alu;
        rf_we = 1'b1; pc_we = 1'b1; retire = 1'b1;
        wbs = is_load ? WB_MEM : ((is_jal || is_jalr) ? WB_PC4 : WB_ALU);
        pcs = is_jal ? PC_JUMP : (is_jalr ? PC_JALR : PC_4);
      end
      S_TRAP: begin
        exc = 1'b1; pcs = PC_EXC; pc_we = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH; wait_q <= 8'd0; cause_q <= 2'd0; retired_q <= '0;
    end else begin
      state_q <= state_d; wait_q <= wait_d; cause_q <= cause_d;
      if (retire) retired_q <= retired_q + COUNTER_WIDTH'(1);
    end
  end

  // Enables are suppressed for as long as reset is asserted
  assign pcWriteEnable      = pc_we & ~rst;
  assign irWriteEnable      = ir_we & ~rst;
  assign regFileWriteEnable = rf_we & ~rst;
  assign memoryReadEnable   = mre & ~rst;
  assign memoryWriteEnable  = mwe & ~rst;
  assign exception          = exc & ~rst;
  assign memAddrSelect      = mas;
  assign pcSelect           = pcs;
  assign op1Select          = op1;
  assign op2Select          = op2;
  assign aluFunction        = alu;
  assign writebackSelect    = wbs;
  assign exceptionCause     = cause_q;
  assign state              = state_q;
  assign retiredCount       = retired_q;

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Bench for riscv_multicycle_control: two configurations driven by directed and
// random instructions, checked cycle by cycle against a per-instruction model.
module tb_riscv_multicycle_control;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwe;
    logic       irwe;
    logic       mas;
    logic [2:0] pcs;
    logic [1:0] op1;
    logic [2:0] op2;
    logic [3:0] alu;
    logic [1:0] wbs;
    logic       rfwe;
    logic       mre;
    logic       mwe;
    logic       exc;
    logic [1:0] cause;
  } obs_t;

  localparam int LIM0 = 8;
  localparam int LIM1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic [31:0] ins [2];
  logic        rdy [2];
  logic        eq  [2];
  logic        lt  [2];
  logic        ltu [2];

  logic       pcwe0, irwe0, mas0, rfwe0, mre0, mwe0, exc0;
  logic [2:0] pcs0, op2s0, st0;
  logic [1:0] op1s0, wbs0, cause0;
  logic [3:0] alu0;
  logic [31:0] rc0;
  logic       pcwe1, irwe1, mas1, rfwe1, mre1, mwe1, exc1;
  logic [2:0] pcs1, op2s1, st1;
  logic [1:0] op1s1, wbs1, cause1;
  logic [3:0] alu1;
  logic [3:0] rc1;
  obs_t obs0, obs1;

  assign obs0 = {st0, pcwe0, irwe0, mas0, pcs0, op1s0, op2s0, alu0, wbs0, rfwe0, mre0, mwe0, exc0, cause0};
  assign obs1 = {st1, pcwe1, irwe1, mas1, pcs1, op1s1, op2s1, alu1, wbs1, rfwe1, mre1, mwe1, exc1, cause1};

  riscv_multicycle_control #(.ENABLE_BRANCH_FULL(1'b1), .MEM_WAIT_LIMIT(LIM0), .COUNTER_WIDTH(32)) dut0 (
    .clk(clk), .rst(rst[0]), .instruction(ins[0]), .memReady(rdy[0]), .isEqual(eq[0]),
    .isLessThan(lt[0]), .isLessThanUnsigned(ltu[0]), .pcWriteEnable(pcwe0), .irWriteEnable(irwe0),
    .memAddrSelect(mas0), .pcSelect(pcs0), .op1Select(op1s0), .op2Select(op2s0), .aluFunction(alu0),
    .writebackSelect(wbs0), .regFileWriteEnable(rfwe0), .memoryReadEnable(mre0),
    .memoryWriteEnable(mwe0), .exception(exc0), .exceptionCause(cause0), .state(st0),
    .retiredCount(rc0));

  riscv_multicycle_control #(.ENABLE_BRANCH_FULL(1'b0), .MEM_WAIT_LIMIT(LIM1), .COUNTER_WIDTH(4)) dut1 (
    .clk(clk), .rst(rst[1]), .instruction(ins[1]), .memReady(rdy[1]), .isEqual(eq[1]),
    .isLessThan(lt[1]), .isLessThanUnsigned(ltu[1]), .pcWriteEnable(pcwe1), .irWriteEnable(irwe1),
    .memAddrSelect(mas1), .pcSelect(pcs1), .op1Select(op1s1), .op2Select(op2s1), .aluFunction(alu1),
    .writebackSelect(wbs1), .regFileWriteEnable(rfwe1), .memoryReadEnable(mre1),
    .memoryWriteEnable(mwe1), .exception(exc1), .exceptionCause(cause1), .state(st1),
    .retiredCount(rc1));

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_ret   = 32'd0;
  logic [1:0]  exp_cause = 2'd0;

  function automatic obs_t base(input logic [2:0] st);
    obs_t e;
    e = '0;
    e.st = st;
    e.cause = exp_cause;
    return e;
  endfunction

  function automatic void retire_model(input int d);
    exp_ret = (exp_ret + 32'd1) & ((d == 0) ? 32'hFFFF_FFFF : 32'h0000_000F);
  endfunction

  // Reference decode: what the instruction means, independent of the FSM
  function automatic void exp_decode(input logic [31:0] i, input bit full_br, output bit legal,
                                     output logic [1:0] o1, output logic [2:0] o2, output logic [3:0] al);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    legal = 1'b1; o1 = 2'd0; o2 = 3'd0; al = 4'd0;
    case (opc)
      7'h37: begin o1 = 2'd1; o2 = 3'd3; end
      7'h17: begin o1 = 2'd2; o2 = 3'd3; end
      7'h6f: begin o1 = 2'd2; o2 = 3'd4; end
      7'h67, 7'h03: o2 = 3'd1;
      7'h13: begin o2 = 3'd1; al = {1'b0, f3}; if (f3 == 3'd5) al[3] = f7[5]; end
      7'h33: begin al = {f7[5], f3}; legal = (f7 == 7'h00) || (f7 == 7'h20); end
      7'h23: o2 = 3'd2;
      7'h63: legal = !(f3 == 3'd2 || f3 == 3'd3) && (full_br || f3 < 3'd4);
      default: legal = 1'b0;
    endcase
  endfunction

  task automatic check(input int d, input obs_t e, input string tag);
    obs_t o;
    logic [31:0] r;
    @(negedge clk);
    o = (d == 0) ? obs0 : obs1;
    r = (d == 0) ? rc0 : 32'(rc1);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s dut%0d controls observed=%b expected=%b", tag, d, o, e);
    end
    checks++;
    assert (r === exp_ret) else begin
      failures++;
      $error("FAIL %s dut%0d retiredCount observed=%0d expected=%0d", tag, d, r, exp_ret);
    end
    @(posedge clk); #1;
  endtask

  task automatic trap(input int d);
    obs_t e;
    rdy[d] = 1'($urandom);
    e = base(3'd5); e.exc = 1'b1; e.pcs = 3'd4; e.pcwe = 1'b1;
    check(d, e, "trap");
  endtask

  // One instruction end to end; eq_mode -1 random operands, 0 unequal, 1 equal
  task automatic run_instr(input int d, input logic [31:0] i, input int fw, input int mw,
                           input int rst_k, input int eq_mode);
    obs_t e;
    bit legal, tk, ld, stv;
    logic [1:0] o1;
    logic [2:0] o2, f3;
    logic [3:0] al;
    logic [6:0] opc;
    logic [31:0] a, b;
    int lim;
    lim = (d == 0) ? LIM0 : LIM1;
    a = $urandom;
    b = (eq_mode == 1 || (eq_mode < 0 && $urandom_range(0, 2) == 0)) ? a : $urandom;
    if (eq_mode == 0 && b == a) b = a + 32'd1;
    eq[d] = (a == b); lt[d] = ($signed(a) < $signed(b)); ltu[d] = (a < b);
    opc = i[6:0]; f3 = i[14:12];
    ld = (opc == 7'h03); stv = (opc == 7'h23);
    exp_decode(i, d == 0, legal, o1, o2, al);

    for (int k = 0; k < 1000; k++) begin
      ins[d] = $urandom; rdy[d] = (k == fw);
      e = base(3'd0); e.mre = 1'b1; e.irwe = rdy[d];
      check(d, e, "fetch");
      if (k == fw) break;
      if (k == lim - 1) begin exp_cause = 2'd2; trap(d); return; end
    end

    ins[d] = i; rdy[d] = 1'($urandom);
    e = base(3'd1);
    check(d, e, "decode");
    if (!legal) begin exp_cause = 2'd1; trap(d); return; end

    rdy[d] = 1'($urandom);
    e = base(3'd2); e.op1 = o1; e.op2 = o2; e.alu = al;
    if (opc == 7'h63) begin
      case (f3)
        3'd0: tk = (a == b);
        3'd1: tk = (a != b);
        3'd4: tk = $signed(a) < $signed(b);
        3'd5: tk = $signed(a) >= $signed(b);
        3'd6: tk = a < b;
        default: tk = a >= b;
      endcase
      e.pcwe = 1'b1; e.pcs = tk ? 3'd1 : 3'd0;
      check(d, e, "branch");
      retire_model(d);
      return;
    end
    check(d, e, "execute");

    if (ld || stv) begin
      for (int k = 0; k < 1000; k++) begin
        rdy[d] = (k == mw);
        e = base(3'd3); e.op1 = o1; e.op2 = o2; e.alu = al;
        e.mas = 1'b1; e.mre = ld; e.mwe = stv;
        if (k == rst_k) begin
          rst[d] = 1'b1; rdy[d] = 1'b1; e.mre = 1'b0; e.mwe = 1'b0;
          check(d, e, "mem_rst");
          rst[d] = 1'b0; exp_ret = 32'd0; exp_cause = 2'd0;
          return;
        end
        if (rdy[d] && stv) e.pcwe = 1'b1;
        check(d, e, "memory");
        if (rdy[d]) begin
          if (stv) begin retire_model(d); return; end
          break;
        end
        if (k == lim - 1) begin exp_cause = 2'd2; trap(d); return; end
      end
    end

    rdy[d] = 1'($urandom);
    e = base(3'd4); e.op1 = o1; e.op2 = o2; e.alu = al; e.rfwe = 1'b1; e.pcwe = 1'b1;
    e.wbs = ld ? 2'd1 : ((opc == 7'h6f || opc == 7'h67) ? 2'd2 : 2'd0);
    e.pcs = (opc == 7'h6f) ? 3'd2 : ((opc == 7'h67) ? 3'd3 : 3'd0);
    check(d, e, "writeback");
    retire_model(d);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [11];
    logic [31:0] i;
    int r;
    opcs = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h0b, 7'h7f};
    i = $urandom;
    i[6:0] = opcs[$urandom_range(0, 10)];
    r = $urandom_range(0, 3);
    if (r == 0) i[31:25] = 7'h00;
    else if (r == 1) i[31:25] = 7'h20;
    return i;
  endfunction

  function automatic int rand_wait(input int lim);
    if ($urandom_range(0, 9) == 0) return $urandom_range(lim - 1, lim + 2);
    return $urandom_range(0, 2);
  endfunction

  task automatic random_run(input int d, input int n);
    int lim;
    lim = (d == 0) ? LIM0 : LIM1;
    for (int n_i = 0; n_i < n; n_i++)
      run_instr(d, rand_instr(), rand_wait(lim), rand_wait(lim), -1, -1);
  endtask

  initial begin
    obs_t e;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; ins[d] = 32'd0; rdy[d] = 1'b0; eq[d] = 1'b0; lt[d] = 1'b0; ltu[d] = 1'b0;
    end
    @(posedge clk); @(posedge clk); #1;
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    e = base(3'd0);
    check(0, e, "reset");
    check(1, e, "reset");

    rst[0] = 1'b0;
    run_instr(0, 32'h0050_0093, 0, 0, -1, -1);   // ADDI
    run_instr(0, 32'h0020_8063, 0, 0, -1, 1);    // BEQ taken
    run_instr(0, 32'h0020_8063, 0, 0, -1, 0);    // BEQ not taken
    run_instr(0, 32'h0020_c063, 1, 0, -1, -1);   // BLT legal here
    run_instr(0, 32'h0000_a183, 0, 3, -1, -1);   // LW, three wait cycles
    run_instr(0, 32'h0020_a023, 2, 1, -1, -1);   // SW
    run_instr(0, 32'h0080_006f, 0, 0, -1, -1);   // JAL
    run_instr(0, 32'h0000_80e7, 0, 0, -1, -1);   // JALR
    run_instr(0, 32'h1234_50b7, 0, 0, -1, -1);   // LUI
    run_instr(0, 32'h0000_1097, 0, 0, -1, -1);   // AUIPC
    run_instr(0, 32'h4020_8033, 0, 0, -1, -1);   // SUB
    run_instr(0, 32'h4020_d033, 0, 0, -1, -1);   // SRA
    run_instr(0, 32'h0220_8033, 0, 0, -1, -1);   // OP funct7=1, illegal
    run_instr(0, 32'h0000_000b, 0, 0, -1, -1);   // unknown opcode
    run_instr(0, 32'h0050_0093, LIM0 - 1, 0, -1, -1);
    run_instr(0, 32'h0020_a023, 0, 3, 1, -1);    // reset during SW memory wait
    run_instr(0, 32'h0050_0093, 0, 0, -1, -1);
    random_run(0, 60);

    rst[0] = 1'b1;
    exp_ret = 32'd0; exp_cause = 2'd0;
    rst[1] = 1'b0;
    run_instr(1, 32'h0020_c063, 0, 0, -1, -1);   // BLT illegal without full branches
    run_instr(1, 32'h0020_9063, 0, 0, -1, 0);    // BNE
    run_instr(1, 32'h0050_0093, 100, 0, -1, -1); // fetch timeout
    run_instr(1, 32'h0000_a183, 0, 100, -1, -1); // load timeout
    for (int n_i = 0; n_i < 17; n_i++) run_instr(1, 32'h0050_0093, 0, 0, -1, -1);
    random_run(1, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_control.md
Name: riscv_multicycle_control

Overview:
Multi-cycle successor to the single-stage RV32 control decoder. A sequential FSM walks each instruction through fetch, decode, execute, memory and writeback, and gates every datapath enable per state. It waits on a memory ready handshake with a bounded timeout. It adds the full branch set (parametrised), AUIPC, illegal-instruction and bus-timeout traps, and a retired-instruction counter. It sits between the shared instruction/data memory port and the existing datapath muxes and ALU.

Parameters:
ENABLE_BRANCH_FULL, 1, 1 = BLT/BGE/BLTU/BGEU legal; 0 = only BEQ/BNE legal, others trap illegal.
MEM_WAIT_LIMIT, 8, max cycles waiting for memReady before bus-error trap; range 1..255.
COUNTER_WIDTH, 32, width of retiredCount.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
instruction  input  32  instruction register contents, valid from DECODE onward
memReady  input  1  memory completes the current read/write this cycle
isEqual  input  1  rs1 == rs2
isLessThan  input  1  rs1 < rs2, signed
isLessThanUnsigned  input  1  rs1 < rs2, unsigned
pcWriteEnable  output  1  PC register load
irWriteEnable  output  1  instruction register load
memAddrSelect  output  1  0 = PC, 1 = ALU result
pcSelect  output  3  existing pc_sel encodings
op1Select  output  2  existing op1Sel encodings plus new op1Sel_pc for AUIPC
op2Select  output  3  existing op2Sel encodings
aluFunction  output  4  existing Alu32b_extended aluOp encodings
writebackSelect  output  2  existing wb_sel encodings
regFileWriteEnable  output  1  register file write
memoryReadEnable  output  1  memory read request
memoryWriteEnable  output  1  memory write request
exception  output  1  high only in TRAP
exceptionCause  output  2  0 none, 1 illegal instruction, 2 bus timeout; registered
state  output  3  current state, debug
retiredCount  output  COUNTER_WIDTH  instructions completed

Behaviour:
- States: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5. Codes 6 and 7 go to FETCH next cycle with all enables 0.
- Reset, rst high at an edge:
  - state -> FETCH; waitCount, retiredCount, exceptionCause -> 0.
  - While rst is high, all enables and exception are forced 0 combinationally, even mid-operation.
- All outputs are a combinational function of state, instruction, flags and memReady. Non-enable selects default to 0.
- FETCH:
  - memAddrSelect=0, memoryReadEnable=1.
  - On memReady: irWriteEnable=1 for that cycle, then DECODE.
  - Otherwise waitCount increments. When waitCount == MEM_WAIT_LIMIT-1 without ready: cause=2, then TRAP.
- DECODE:
  - Legal opcodes: LUI, AUIPC, JAL, JALR, OP-IMM, OP, LOAD(LW), STORE(SW), BRANCH.
  - Illegal: any other opcode; BRANCH funct3 010/011; BRANCH funct3 1xx when ENABLE_BRANCH_FULL=0; OP funct7 other than ADD/SUB/SRL/SRA forms.
  - Illegal: cause=1, then TRAP. Legal: EXECUTE.
- EXECUTE through WRITEBACK: aluFunction, op1Select and op2Select are held at the decoded values, using the same decode as the single-stage control. AUIPC uses op1Sel_pc with U-type immediate via op2. LW/SW force add.
- EXECUTE:
  - BRANCH: pcWriteEnable=1 this cycle. pcSelect=branch when taken, else pc_4. Taken conditions: BEQ isEqual, BNE !isEqual, BLT isLessThan, BGE !isLessThan, BLTU isLessThanUnsigned, BGEU !isLessThanUnsigned. retire, then FETCH.
  - LW/SW: go to MEMORY, waitCount cleared.
  - All others: go to WRITEBACK.
- MEMORY:
  - memAddrSelect=1; memoryReadEnable (LW) or memoryWriteEnable (SW) held until memReady. Same timeout rule as FETCH.
  - On ready, LW: WRITEBACK.
  - On ready, SW: pcWriteEnable=1, pcSelect=pc_4, retire, then FETCH.
- WRITEBACK:
  - regFileWriteEnable=1 (x0 writes are ignored by the register file).
  - writebackSelect: memoryOut for LW, pc_4 for JAL/JALR, aluOut otherwise.
  - pcWriteEnable=1; pcSelect: jump for JAL, jalr for JALR, pc_4 otherwise. retire, then FETCH.
- TRAP: exception=1, pcSelect=exception, pcWriteEnable=1 for exactly one cycle, then FETCH. exceptionCause holds until the next trap or reset. No retire.
- Retire: retiredCount+1, wrapping modulo 2^COUNTER_WIDTH.
- memReady is ignored outside FETCH and MEMORY. waitCount clears on every state entry.
- Latency with zero-wait memory: branch 3 cycles, ALU/LUI/AUIPC/JAL/JALR 4, SW 4, LW 5.

Test Plan:
- ADDI x1,x0,5 (0x00500093), memReady always 1 -> states 0,1,2,4 then 0. Regfile write with aluOut in cycle 4, pc_4; retiredCount 0 -> 1.
- BEQ with isEqual=1 -> pcWriteEnable at EXECUTE with pcSelect=branch, no regfile write. With isEqual=0 -> pcSelect=pc_4.
- BLT (funct3 100) with ENABLE_BRANCH_FULL=0 -> DECODE to TRAP, exception for 1 cycle, exceptionCause=1, retiredCount unchanged.
- LW with memReady low 3 cycles in MEMORY -> memoryReadEnable held 4 cycles. Then WRITEBACK with memoryOut; 8 cycles total.
- MEM_WAIT_LIMIT=4, memReady stuck low in FETCH -> TRAP after 4 FETCH cycles, exceptionCause=2.
- rst pulsed while in MEMORY for SW -> enables 0 that cycle, state=FETCH, counters 0, no write completes.
- retiredCount at all-ones with COUNTER_WIDTH=4 -> next retire wraps to 0.
